// File: rtl/float_to_int_seq_pkg.sv
// rtl/float_to_int_seq_pkg.sv - shared constants, state encoding and helpers for the float-to-int converter
package float_to_int_seq_pkg;

  localparam int BIAS   = 127;
  localparam int MANT_W = 23;
  localparam int INT_W  = 32;

  localparam logic [7:0] EXP_MAX   = 8'hFF;
  localparam logic [7:0] EXP_BIAS  = 8'(BIAS);
  // Exponent at which the 24-bit significand is already integer-aligned (k=0).
  localparam logic [7:0] EXP_ALIGN = 8'(BIAS + MANT_W);
  // First exponent whose magnitude no longer fits a positive INT_W-bit value.
  localparam logic [7:0] EXP_SAT   = 8'(BIAS + INT_W - 1);

  localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } convState_t;

  function automatic logic [INT_W-1:0] applySign(input logic neg, input logic [INT_W-1:0] mag);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

  function automatic logic [INT_W-1:0] satValue(input logic neg);
    return neg ? INT_MIN : INT_MAX;
  endfunction

endpackage

// File: rtl/float_fields.sv
// rtl/float_fields.sv - combinational split of a single-precision float into fields and class bits
module float_fields
  import float_to_int_seq_pkg::*;
(
  input  logic [31:0]       data,
  output logic              sign,
  output logic [7:0]        expField,
  output logic [MANT_W-1:0] mant,
  output logic              isNan,
  output logic              isInf,
  output logic              isSmall
);

  assign sign     = data[31];
  assign expField = data[30:23];
  assign mant     = data[MANT_W-1:0];

  assign isNan   = (expField == EXP_MAX) && (mant != '0);
  assign isInf   = (expField == EXP_MAX) && (mant == '0);
  // Zero, subnormals and any |value| < 1 truncate to 0.
  assign isSmall = expField < EXP_BIAS;

endmodule

// File: rtl/float_to_int_seq.sv
// rtl/float_to_int_seq.sv - sequential float32 to int32 converter with a one-bit-per-cycle aligner
module float_to_int_seq
  import float_to_int_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      data_i,
  output logic [INT_W-1:0] data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic             invalid_o
);

  convState_t        state, stateNext;
  logic [INT_W-1:0]  mag, magNext;
  logic [4:0]        cnt, cntNext;
  logic              shiftLeft, shiftLeftNext;
  logic              signQ, signNext;
  logic [INT_W-1:0]  dataQ, dataNext;
  logic              ovfQ, ovfNext;
  logic              invQ, invNext;

  logic              fSign, fNan, fInf, fSmall, fLeft;
  logic [7:0]        fExp;
  logic [MANT_W-1:0] fMant;
  logic [INT_W-1:0]  fMag, shifted;
  logic [4:0]        fK;

  float_fields uFields (
    .data     (data_i),
    .sign     (fSign),
    .expField (fExp),
    .mant     (fMant),
    .isNan    (fNan),
    .isInf    (fInf),
    .isSmall  (fSmall)
  );

  assign fMag  = {8'd0, 1'b1, fMant};
  assign fLeft = fExp >= EXP_ALIGN;
  // Only meaningful on the normal path, where the distance is at most 23.
  assign fK    = fLeft ? 5'(fExp - EXP_ALIGN) : 5'(EXP_ALIGN - fExp);

  assign shifted = shiftLeft ? {mag[INT_W-2:0], 1'b0} : {1'b0, mag[INT_W-1:1]};

  always_comb begin
    stateNext     = state;
    magNext       = mag;
    cntNext       = cnt;
    shiftLeftNext = shiftLeft;
    signNext      = signQ;
    dataNext      = dataQ;
    ovfNext       = ovfQ;
    invNext       = invQ;
    case (state)
      ST_SHIFT: begin
        magNext = shifted;
        cntNext = cnt - 5'd1;
        if (cnt == 5'd1) begin
          stateNext = ST_FINISH;
          dataNext  = applySign(signQ, shifted);
          ovfNext   = 1'b0;
          invNext   = 1'b0;
        end
      end
      default: begin
        // FINISH accepts a new start exactly like IDLE, allowing back-to-back requests.
        stateNext = ST_IDLE;
        if (start_i) begin
          stateNext     = ST_FINISH;
          signNext      = fSign;
          magNext       = fMag;
          cntNext       = fK;
          shiftLeftNext = fLeft;
          ovfNext       = 1'b0;
          invNext       = 1'b0;
          if (fNan) begin
            invNext  = 1'b1;
            dataNext = INT_MIN;
          end else if (fInf) begin
            ovfNext  = 1'b1;
            dataNext = satValue(fSign);
          end else if (fSmall) begin
            dataNext = '0;
          end else if (fExp >= EXP_SAT) begin
            if (fSign && fExp == EXP_SAT && fMant == '0) begin
              dataNext = INT_MIN;
            end else begin
              ovfNext  = 1'b1;
              dataNext = satValue(fSign);
            end
          end else if (fK == 5'd0) begin
            dataNext = applySign(fSign, fMag);
          end else begin
            stateNext = ST_SHIFT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mag       <= '0;
      cnt       <= '0;
      shiftLeft <= 1'b0;
      signQ     <= 1'b0;
      dataQ     <= '0;
      ovfQ      <= 1'b0;
      invQ      <= 1'b0;
    end else begin
      state     <= stateNext;
      mag       <= magNext;
      cnt       <= cntNext;
      shiftLeft <= shiftLeftNext;
      signQ     <= signNext;
      dataQ     <= dataNext;
      ovfQ      <= ovfNext;
      invQ      <= invNext;
    end
  end

  assign data_o     = dataQ;
  assign overflow_o = ovfQ;
  assign invalid_o  = invQ;
  assign done_o     = (state == ST_FINISH);
  assign busy_o     = (state != ST_IDLE);

endmodule

// File: tb/tb_float_to_int_seq.sv
// tb/tb_float_to_int_seq.sv - directed self-checking bench for float_to_int_seq
module tb_float_to_int_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        busy_o, done_o, overflow_o, invalid_o;

  float_to_int_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overflow_o (overflow_o),
    .invalid_o  (invalid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        inv;
    int          lat;
  } expT;

  expT sb[$];
  int  checks = 0;
  int  passed = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
  endtask

  // Called at posedge+1; a junk start is injected at cycle injectAt (0 = none).
  task automatic convert(input logic [31:0] f, input logic [31:0] expData, input logic expOvf,
                         input logic expInv, input int expLat, input int injectAt);
    expT e;
    int  lat;
    logic seen;
    e.data = expData; e.ovf = expOvf; e.inv = expInv; e.lat = expLat;
    sb.push_back(e);
    start_i = 1'b1;
    data_i  = f;
    @(posedge clk); #1;
    start_i = 1'b0;
    data_i  = 32'h0;
    lat  = 1;
    seen = done_o;
    if (expLat > 1) checkBit($sformatf("busy_early_%h", f), busy_o, 1'b1);
    while (!seen && lat < 40) begin
      if (lat == injectAt) begin
        start_i = 1'b1;
        data_i  = 32'h4F00_0000;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      data_i  = 32'h0;
      lat++;
      seen = done_o;
    end
    e = sb.pop_front();
    checkBit($sformatf("done_seen_%h", f), seen, 1'b1);
    checkBit($sformatf("busy_at_done_%h", f), busy_o, 1'b1);
    check32($sformatf("data_%h", f), data_o, e.data);
    checkBit($sformatf("ovf_%h", f), overflow_o, e.ovf);
    checkBit($sformatf("inv_%h", f), invalid_o, e.inv);
    check32($sformatf("latency_%h", f), 32'(lat), 32'(e.lat));
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    data_i  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_data", data_o, 32'h0);
    checkBit("reset_busy", busy_o, 1'b0);
    checkBit("reset_done", done_o, 1'b0);
    checkBit("reset_ovf", overflow_o, 1'b0);
    checkBit("reset_inv", invalid_o, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    convert(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 24, 0);
    convert(32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 23, 0);
    convert(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 8, 0);
    convert(32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 1, 0);
    convert(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1, 0);
    convert(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1, 0);
    convert(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1, 0);
    convert(32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1, 1, 0);
    convert(32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1, 0);
    convert(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1, 0);
    convert(32'h42F7_0000, 32'h0000_007B, 1'b0, 1'b0, 18, 0);
    convert(32'hC2F7_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 18, 0);
    convert(32'h4F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1, 0);
    convert(32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 1, 0);

    // done_o is a single-cycle pulse and results hold while idle.
    @(posedge clk); #1;
    checkBit("done_no_stretch", done_o, 1'b0);
    checkBit("busy_idle", busy_o, 1'b0);
    check32("data_held", data_o, 32'h8000_0000);
    checkBit("ovf_held", overflow_o, 1'b1);

    convert(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 24, 5);

    // Abort a conversion with reset while an overflow result is still held.
    convert(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1, 0);
    start_i = 1'b1;
    data_i  = 32'h3F80_0000;
    @(posedge clk); #1;
    start_i = 1'b0;
    data_i  = 32'h0;
    repeat (5) @(posedge clk);
    #1;
    checkBit("busy_mid_shift", busy_o, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check32("abort_data", data_o, 32'h0);
    checkBit("abort_busy", busy_o, 1'b0);
    checkBit("abort_done", done_o, 1'b0);
    checkBit("abort_ovf", overflow_o, 1'b0);
    checkBit("abort_inv", invalid_o, 1'b0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkBit("abort_no_late_done", done_o, 1'b0);
    convert(32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
